mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- 2-to-1 arbiter for the uncore memory request/response bus.
- Sits directly upstream of the simulated device port and merges the instruction-side (in0) and data-side (in1) masters onto one out_* port.
- Round-robin grant, with the grant held stable while the downstream stalls.
- An in-order owner FIFO steers each response back to the master that issued the request, so up to DEPTH requests can be outstanding.

Parameters:
- DEPTH, 2: maximum outstanding requests (owner FIFO entries); must be a power of two, at least 1.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- inN_req_valid  in  1  request valid from master N (N = 0, 1).
- inN_req_ready  out  1  request accepted from master N.
- inN_req_bits_is_cached  in  1  cacheable flag.
- inN_req_bits_addr  in  ADDR_W  byte address.
- inN_req_bits_len  in  2  log2 of access size.
- inN_req_bits_data  in  DATA_W  write data.
- inN_req_bits_func  in  1  0 = read, 1 = write.
- inN_req_bits_strb  in  4  byte write strobes.
- inN_resp_ready  in  1  master N can take a response.
- inN_resp_valid  out  1  response valid to master N.
- inN_resp_bits_data  out  DATA_W  response data.
- out_req_valid / out_req_ready / out_req_bits_*  out/in  same widths as above  forwarded request to the device.
- out_resp_valid  in  1  response valid from the device.
- out_resp_ready  out  1  ready for a device response.
- out_resp_bits_data  in  DATA_W  response data from the device.

Behaviour:
State:
- last_grant (1b): reset value 1, so in0 wins the first contest.
- lock_valid, lock_id (1b each): reset value 0.
- Owner FIFO: DEPTH x 1b, rd/wr pointers plus count; reset empty.
- Reset is asynchronous and may assert mid-transaction. It clears all of the above immediately, and any in-flight response is discarded.

Selection (combinational):
- If lock_valid, sel = lock_id.
- Else if both masters are valid, sel = ~last_grant.
- Else sel = whichever master is valid.

Request path:
- out_req_valid = inSel_req_valid && !fifo_full.
- out_req_bits_* = inSel_req_bits_*.
- inSel_req_ready = out_req_ready && !fifo_full; the other master's ready = 0.
- Zero-latency pass-through; no request buffering.

Request fire (out_req_valid && out_req_ready):
- Push sel into the owner FIFO.
- last_grant <= sel.
- lock_valid <= 0.

Stall (out_req_valid && !out_req_ready):
- lock_valid <= 1, lock_id <= sel.
- This keeps the presented request stable even if the other master asserts valid meanwhile.

FIFO full:
- No request is forwarded; the lock state is unchanged.
- Push is blocked while full even if a pop occurs in the same cycle. This keeps any ready-to-ready combinational path out of the request side.

Response path:
- head = FIFO head owner.
- inHead_resp_valid = out_resp_valid && !fifo_empty; the other master's resp_valid = 0.
- Both inN_resp_bits_data = out_resp_bits_data.
- out_resp_ready = inHead_resp_ready when the FIFO is non-empty.
- On response fire, pop the head.

Simultaneous push and pop (not full): both happen; count is unchanged; pointers wrap modulo DEPTH.

Protocol error, out_resp_valid while the FIFO is empty:
- out_resp_ready = 1 and the response is dropped.
- Simulation-only assertion fires.

Outputs at reset:
- out_req_valid = 0 and inN_resp_valid = 0, except as combinationally implied by inputs.
- The FIFO is empty, so no response is routed.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the request struct (is_cached, addr, len, data, func, strb);
  - FUNC_READ = 0 and FUNC_WRITE = 1;
  - the LEN_* encodings.
- One natural sub-module, owner_fifo: parameterised depth and width, push/pop/full/empty, asynchronous active-low reset. It is reused later for ID tracking.

Test Plan:
- Single master: in0 read at addr 0x1000; out_req_ready = 1; device responds 0xDEADBEEF after 1 cycle -> in0_resp_valid with 0xDEADBEEF, in1_resp_valid stays 0, FIFO empty again.
- Contention: both masters valid every cycle, out_req_ready = 1 -> grants alternate 0,1,0,1 starting with in0. Responses 0x11, 0x22, 0x33, 0x44 are routed to in0, in1, in0, in1 respectively.
- Stall lock: in1 valid alone with out_req_ready = 0 for 3 cycles, then in0 also asserts valid -> out_req_bits remain in1's (addr 0x2000, strb 0xF) until accepted; in0 is granted next.
- Full: DEPTH = 2, two requests issued, no response -> third request sees out_req_valid = 0 and ready = 0. One response pops the head; the third request is accepted the following cycle.
- Backpressure: response for in0 while in0_resp_ready = 0 for 2 cycles -> out_resp_ready = 0, data held, no pop until ready rises.
- Reset mid-flight: reset_n low with 2 requests outstanding -> FIFO empty and last_grant = 1 immediately. After release, the first contested request goes to in0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the uncore memory request/response bus:
// request fields, function and size encodings, and the owner tag type.
package mem_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  localparam logic FUNC_READ  = 1'b0;
  localparam logic FUNC_WRITE = 1'b1;

  // len carries log2 of the access size in bytes
  localparam logic [1:0] LEN_BYTE  = 2'd0;
  localparam logic [1:0] LEN_HALF  = 2'd1;
  localparam logic [1:0] LEN_WORD  = 2'd2;
  localparam logic [1:0] LEN_DWORD = 2'd3;

  typedef logic owner_t;
  localparam owner_t OWNER_IN0 = 1'b0;
  localparam owner_t OWNER_IN1 = 1'b1;

  typedef struct packed {
    logic                  is_cached;
    logic [BUS_ADDR_W-1:0] addr;
    logic [1:0]            len;
    logic [BUS_DATA_W-1:0] data;
    logic                  func;
    logic [3:0]            strb;
  } mem_req_t;

endpackage

// File: rtl/mem_req_arbiter_chk.sv
// Protocol checks for mem_req_arbiter; simulation-only, no functional effect.
module mem_req_arbiter_chk (
  input logic clock_i,
  input logic reset_ni,
  input logic out_resp_valid_i,
  input logic out_req_valid_i,
  input logic fifo_empty_i,
  input logic fifo_full_i
);

  // A device response with nothing outstanding is dropped by the arbiter.
  resp_without_req_a: assert property (
    @(posedge clock_i) disable iff (!reset_ni) !(out_resp_valid_i && fifo_empty_i)
  );

  no_req_when_full_a: assert property (
    @(posedge clock_i) disable iff (!reset_ni) !(out_req_valid_i && fifo_full_i)
  );

endmodule

// File: rtl/owner_fifo.sv
// Small in-order tag FIFO with push/pop/full/empty. Push is ignored while full
// and pop is ignored while empty, so callers never corrupt the occupancy.
module owner_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_s, pop_s;

  // Explicit wrap keeps non-power-of-two pointer widths (DEPTH = 1) correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == CNT_W'(0));
  assign data_o  = mem_q[rd_ptr_q];
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin 2:1 merge of instruction-side (in0) and data-side (in1) masters
// onto one device port; an owner FIFO routes in-order responses back.
module mem_req_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              in0_req_valid,
  output logic              in0_req_ready,
  input  logic              in0_req_bits_is_cached,
  input  logic [ADDR_W-1:0] in0_req_bits_addr,
  input  logic [1:0]        in0_req_bits_len,
  input  logic [DATA_W-1:0] in0_req_bits_data,
  input  logic              in0_req_bits_func,
  input  logic [3:0]        in0_req_bits_strb,
  input  logic              in0_resp_ready,
  output logic              in0_resp_valid,
  output logic [DATA_W-1:0] in0_resp_bits_data,

  input  logic              in1_req_valid,
  output logic              in1_req_ready,
  input  logic              in1_req_bits_is_cached,
  input  logic [ADDR_W-1:0] in1_req_bits_addr,
  input  logic [1:0]        in1_req_bits_len,
  input  logic [DATA_W-1:0] in1_req_bits_data,
  input  logic              in1_req_bits_func,
  input  logic [3:0]        in1_req_bits_strb,
  input  logic              in1_resp_ready,
  output logic              in1_resp_valid,
  output logic [DATA_W-1:0] in1_resp_bits_data,

  output logic              out_req_valid,
  input  logic              out_req_ready,
  output logic              out_req_bits_is_cached,
  output logic [ADDR_W-1:0] out_req_bits_addr,
  output logic [1:0]        out_req_bits_len,
  output logic [DATA_W-1:0] out_req_bits_data,
  output logic              out_req_bits_func,
  output logic [3:0]        out_req_bits_strb,
  input  logic              out_resp_valid,
  output logic              out_resp_ready,
  input  logic [DATA_W-1:0] out_resp_bits_data
);

  typedef struct packed {
    logic              is_cached;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        len;
    logic [DATA_W-1:0] data;
    logic              func;
    logic [3:0]        strb;
  } req_bits_t;

  req_bits_t in0_bits_s, in1_bits_s, sel_bits_s;
  owner_t    sel_s, head_s;
  logic      sel_valid_s;
  logic      fifo_full_s, fifo_empty_s;
  logic      req_fire_s, req_stall_s, resp_fire_s;

  owner_t    last_grant_q, last_grant_d;
  logic      lock_valid_q, lock_valid_d;
  owner_t    lock_id_q, lock_id_d;

  assign in0_bits_s = '{is_cached: in0_req_bits_is_cached, addr: in0_req_bits_addr,
                        len: in0_req_bits_len, data: in0_req_bits_data,
                        func: in0_req_bits_func, strb: in0_req_bits_strb};
  assign in1_bits_s = '{is_cached: in1_req_bits_is_cached, addr: in1_req_bits_addr,
                        len: in1_req_bits_len, data: in1_req_bits_data,
                        func: in1_req_bits_func, strb: in1_req_bits_strb};

  // A stalled request keeps the bus; otherwise alternate under contention.
  always_comb begin
    sel_s = OWNER_IN0;
    if (lock_valid_q) begin
      sel_s = lock_id_q;
    end else if (in0_req_valid && in1_req_valid) begin
      sel_s = owner_t'(~last_grant_q);
    end else if (in1_req_valid) begin
      sel_s = OWNER_IN1;
    end else begin
      sel_s = OWNER_IN0;
    end
  end

  always_comb begin
    sel_bits_s  = in0_bits_s;
    sel_valid_s = in0_req_valid;
    if (sel_s == OWNER_IN1) begin
      sel_bits_s  = in1_bits_s;
      sel_valid_s = in1_req_valid;
    end else begin
      sel_bits_s  = in0_bits_s;
      sel_valid_s = in0_req_valid;
    end
  end

  assign out_req_valid          = sel_valid_s && !fifo_full_s;
  assign out_req_bits_is_cached = sel_bits_s.is_cached;
  assign out_req_bits_addr      = sel_bits_s.addr;
  assign out_req_bits_len       = sel_bits_s.len;
  assign out_req_bits_data      = sel_bits_s.data;
  assign out_req_bits_func      = sel_bits_s.func;
  assign out_req_bits_strb      = sel_bits_s.strb;
  assign in0_req_ready = (sel_s == OWNER_IN0) && out_req_ready && !fifo_full_s;
  assign in1_req_ready = (sel_s == OWNER_IN1) && out_req_ready && !fifo_full_s;

  assign req_fire_s  = out_req_valid && out_req_ready;
  assign req_stall_s = out_req_valid && !out_req_ready;

  always_comb begin
    last_grant_d = last_grant_q;
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    if (req_fire_s) begin
      last_grant_d = sel_s;
      lock_valid_d = 1'b0;
    end else if (req_stall_s) begin
      lock_valid_d = 1'b1;
      lock_id_d    = sel_s;
    end else begin
      lock_valid_d = lock_valid_q;
      lock_id_d    = lock_id_q;
    end
  end

  // last_grant resets to in1 so that in0 wins the first contest.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= OWNER_IN1;
      lock_valid_q <= 1'b0;
      lock_id_q    <= OWNER_IN0;
    end else begin
      last_grant_q <= last_grant_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
    end
  end

  assign in0_resp_valid     = out_resp_valid && !fifo_empty_s && (head_s == OWNER_IN0);
  assign in1_resp_valid     = out_resp_valid && !fifo_empty_s && (head_s == OWNER_IN1);
  assign in0_resp_bits_data = out_resp_bits_data;
  assign in1_resp_bits_data = out_resp_bits_data;

  // With nothing outstanding a stray response is accepted and dropped.
  assign out_resp_ready = fifo_empty_s ? 1'b1
                        : ((head_s == OWNER_IN1) ? in1_resp_ready : in0_resp_ready);
  assign resp_fire_s    = out_resp_valid && out_resp_ready && !fifo_empty_s;

  owner_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (1)
  ) u_owner_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (req_fire_s),
    .data_i  (sel_s),
    .pop_i   (resp_fire_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  mem_req_arbiter_chk u_chk (
    .clock_i          (clock),
    .reset_ni         (reset_n),
    .out_resp_valid_i (out_resp_valid),
    .out_req_valid_i  (out_req_valid),
    .fifo_empty_i     (fifo_empty_s),
    .fifo_full_i      (fifo_full_s)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based model of grants and response owners.
module tb_mem_req_arbiter;
  import mem_bus_pkg::*;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic              req_v      [2];
  logic              req_cached [2];
  logic [ADDR_W-1:0] req_addr   [2];
  logic [1:0]        req_len    [2];
  logic [DATA_W-1:0] req_data   [2];
  logic              req_func   [2];
  logic [3:0]        req_strb   [2];
  logic              resp_rdy   [2];

  logic              in0_req_ready, in1_req_ready;
  logic              in0_resp_valid, in1_resp_valid;
  logic [DATA_W-1:0] in0_resp_bits_data, in1_resp_bits_data;
  logic              out_req_valid, out_req_ready;
  logic              out_req_bits_is_cached, out_req_bits_func;
  logic [ADDR_W-1:0] out_req_bits_addr;
  logic [1:0]        out_req_bits_len;
  logic [DATA_W-1:0] out_req_bits_data;
  logic [3:0]        out_req_bits_strb;
  logic              out_resp_valid, out_resp_ready;
  logic [DATA_W-1:0] out_resp_bits_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_req_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in0_req_valid(req_v[0]), .in0_req_ready(in0_req_ready),
    .in0_req_bits_is_cached(req_cached[0]), .in0_req_bits_addr(req_addr[0]),
    .in0_req_bits_len(req_len[0]), .in0_req_bits_data(req_data[0]),
    .in0_req_bits_func(req_func[0]), .in0_req_bits_strb(req_strb[0]),
    .in0_resp_ready(resp_rdy[0]), .in0_resp_valid(in0_resp_valid),
    .in0_resp_bits_data(in0_resp_bits_data),
    .in1_req_valid(req_v[1]), .in1_req_ready(in1_req_ready),
    .in1_req_bits_is_cached(req_cached[1]), .in1_req_bits_addr(req_addr[1]),
    .in1_req_bits_len(req_len[1]), .in1_req_bits_data(req_data[1]),
    .in1_req_bits_func(req_func[1]), .in1_req_bits_strb(req_strb[1]),
    .in1_resp_ready(resp_rdy[1]), .in1_resp_valid(in1_resp_valid),
    .in1_resp_bits_data(in1_resp_bits_data),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
    .out_req_bits_is_cached(out_req_bits_is_cached), .out_req_bits_addr(out_req_bits_addr),
    .out_req_bits_len(out_req_bits_len), .out_req_bits_data(out_req_bits_data),
    .out_req_bits_func(out_req_bits_func), .out_req_bits_strb(out_req_bits_strb),
    .out_resp_valid(out_resp_valid), .out_resp_ready(out_resp_ready),
    .out_resp_bits_data(out_resp_bits_data)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      req_v[m] = 1'b0; req_cached[m] = 1'b0; req_addr[m] = '0; req_len[m] = LEN_WORD;
      req_data[m] = '0; req_func[m] = FUNC_READ; req_strb[m] = 4'h0; resp_rdy[m] = 1'b0;
    end
    out_req_ready = 1'b0;
    out_resp_valid = 1'b0;
    out_resp_bits_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic set_req(input int m, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                         input logic func, input logic [3:0] strb);
    req_v[m] = 1'b1; req_addr[m] = addr; req_data[m] = data; req_func[m] = func;
    req_strb[m] = strb; req_len[m] = LEN_WORD; req_cached[m] = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    settle();
    n_checks++; if (out_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_req_valid: got %b want 0", out_req_valid); end
    n_checks++; if (in0_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in0_resp_valid: got %b want 0", in0_resp_valid); end
    n_checks++; if (in1_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in1_resp_valid: got %b want 0", in1_resp_valid); end
    n_checks++; if (out_resp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fifo_empty: out_resp_ready got %b want 1", out_resp_ready); end
    set_req(0, 32'h0000_00A0, 32'h1, FUNC_READ, 4'h0);
    set_req(1, 32'h0000_00B0, 32'h2, FUNC_READ, 4'h0);
    out_req_ready = 1'b1;
    #1;
    n_checks++; if (in0_req_ready !== 1'b1 || in1_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_first_contest: rdy0=%b rdy1=%b want 1/0", in0_req_ready, in1_req_ready); end
    n_checks++; if (out_req_bits_addr !== 32'h0000_00A0) begin n_fail++; $display("FAIL reset_first_addr: got %h want 000000a0", out_req_bits_addr); end
  endtask

  task automatic test_single();
    apply_reset();
    set_req(0, 32'h0000_1000, 32'h0, FUNC_READ, 4'h0);
    out_req_ready = 1'b1;
    settle();
    n_checks++; if (out_req_valid !== 1'b1 || out_req_bits_addr !== 32'h1000 || out_req_bits_func !== FUNC_READ) begin n_fail++; $display("FAIL single_req: valid=%b addr=%h func=%b want 1/1000/0", out_req_valid, out_req_bits_addr, out_req_bits_func); end
    n_checks++; if (in0_req_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", in0_req_ready); end
    step();
    req_v[0] = 1'b0; out_req_ready = 1'b0;
    out_resp_valid = 1'b1; out_resp_bits_data = 32'hDEAD_BEEF; resp_rdy[0] = 1'b1;
    settle();
    n_checks++; if (in0_resp_valid !== 1'b1 || in0_resp_bits_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_resp: valid=%b data=%h want 1/deadbeef", in0_resp_valid, in0_resp_bits_data); end
    n_checks++; if (in1_resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_in1_quiet: got %b want 0", in1_resp_valid); end
    step();
    out_resp_valid = 1'b0; resp_rdy[0] = 1'b0;
    settle();
    n_checks++; if (out_resp_ready !== 1'b1) begin n_fail++; $display("FAIL single_empty_after: out_resp_ready got %b want 1", out_resp_ready); end
  endtask

  task automatic test_contention();
    logic [DATA_W-1:0] rsp [4];
    rsp[0] = 32'h11; rsp[1] = 32'h22; rsp[2] = 32'h33; rsp[3] = 32'h44;
    apply_reset();
    set_req(0, 32'h0000_00A0, 32'hA, FUNC_READ, 4'h0);
    set_req(1, 32'h0000_00B0, 32'hB, FUNC_WRITE, 4'hF);
    out_req_ready = 1'b1; resp_rdy[0] = 1'b1; resp_rdy[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_v[0] = (i < 4); req_v[1] = (i < 4);
      out_resp_valid = (i >= 1);
      if (i >= 1) out_resp_bits_data = rsp[i-1];
      settle();
      if (i < 4) begin
        n_checks++; if (out_req_bits_addr !== ((i % 2 == 0) ? 32'h00A0 : 32'h00B0) || in0_req_ready !== (i % 2 == 0)) begin n_fail++; $display("FAIL contention_grant%0d: addr=%h rdy0=%b", i, out_req_bits_addr, in0_req_ready); end
      end
      if (i >= 1) begin
        n_checks++; if (in0_resp_valid !== ((i - 1) % 2 == 0) || in1_resp_valid !== ((i - 1) % 2 == 1) || in0_resp_bits_data !== rsp[i-1]) begin n_fail++; $display("FAIL contention_resp%0d: v0=%b v1=%b data=%h want data %h", i - 1, in0_resp_valid, in1_resp_valid, in0_resp_bits_data, rsp[i-1]); end
      end
      step();
    end
  endtask

  task automatic test_stall_lock();
    apply_reset();
    set_req(1, 32'h0000_2000, 32'hCAFE_0001, FUNC_WRITE, 4'hF);
    out_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) set_req(0, 32'h0000_1000, 32'h0, FUNC_READ, 4'h1);
      settle();
      n_checks++; if (out_req_valid !== 1'b1 || out_req_bits_addr !== 32'h2000 || out_req_bits_strb !== 4'hF || in0_req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: valid=%b addr=%h strb=%h rdy0=%b", i, out_req_valid, out_req_bits_addr, out_req_bits_strb, in0_req_ready); end
      step();
    end
    out_req_ready = 1'b1;
    settle();
    n_checks++; if (out_req_bits_addr !== 32'h2000 || in1_req_ready !== 1'b1 || in0_req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_accept: addr=%h rdy1=%b rdy0=%b want 2000/1/0", out_req_bits_addr, in1_req_ready, in0_req_ready); end
    step();
    req_v[1] = 1'b0;
    settle();
    n_checks++; if (out_req_bits_addr !== 32'h1000 || in0_req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_next_in0: addr=%h rdy0=%b want 1000/1", out_req_bits_addr, in0_req_ready); end
    step();
  endtask

  task automatic test_full();
    apply_reset();
    out_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_req(0, 32'h0000_3000 + 32'(i * 4), 32'h0, FUNC_READ, 4'h0);
      settle();
      n_checks++; if (in0_req_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d: rdy0=%b want 1", i, in0_req_ready); end
      step();
    end
    set_req(0, 32'h0000_3008, 32'h0, FUNC_READ, 4'h0);
    settle();
    n_checks++; if (out_req_valid !== 1'b0 || in0_req_ready !== 1'b0) begin n_fail++; $display("FAIL full_blocked: valid=%b rdy0=%b want 0/0", out_req_valid, in0_req_ready); end
    step();
    out_resp_valid = 1'b1; out_resp_bits_data = 32'h77; resp_rdy[0] = 1'b1;
    settle();
    n_checks++; if (out_req_valid !== 1'b0 || in0_resp_valid !== 1'b1) begin n_fail++; $display("FAIL full_pop_cycle: req_valid=%b resp_valid=%b want 0/1", out_req_valid, in0_resp_valid); end
    step();
    out_resp_valid = 1'b0;
    settle();
    n_checks++; if (out_req_valid !== 1'b1 || in0_req_ready !== 1'b1 || out_req_bits_addr !== 32'h3008) begin n_fail++; $display("FAIL full_after_pop: valid=%b rdy0=%b addr=%h", out_req_valid, in0_req_ready, out_req_bits_addr); end
    step();
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_req(0, 32'h0000_4000, 32'h0, FUNC_READ, 4'h0);
    out_req_ready = 1'b1;
    step();
    idle_inputs();
    out_resp_valid = 1'b1; out_resp_bits_data = 32'h5A5A_5A5A;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++; if (in0_resp_valid !== 1'b1 || out_resp_ready !== 1'b0 || in0_resp_bits_data !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL backpressure_hold%0d: v=%b ready=%b data=%h", i, in0_resp_valid, out_resp_ready, in0_resp_bits_data); end
      step();
    end
    resp_rdy[0] = 1'b1;
    settle();
    n_checks++; if (out_resp_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure_release: ready=%b want 1", out_resp_ready); end
    step();
    out_resp_valid = 1'b0; resp_rdy[0] = 1'b0;
    settle();
    n_checks++; if (out_resp_ready !== 1'b1 || in0_resp_valid !== 1'b0) begin n_fail++; $display("FAIL backpressure_popped: ready=%b v0=%b want 1/0", out_resp_ready, in0_resp_valid); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    set_req(0, 32'h0000_00A0, 32'h0, FUNC_READ, 4'h0);
    set_req(1, 32'h0000_00B0, 32'h0, FUNC_READ, 4'h0);
    out_req_ready = 1'b1; resp_rdy[0] = 1'b1; resp_rdy[1] = 1'b1;
    step();
    out_resp_valid = 1'b1; out_resp_bits_data = 32'h11;
    step();
    out_resp_valid = 1'b0;
    step();
    settle();
    n_checks++; if (out_req_valid !== 1'b0) begin n_fail++; $display("FAIL midflight_two_outstanding: req_valid=%b want 0", out_req_valid); end
    resp_rdy[0] = 1'b0; resp_rdy[1] = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++; if (out_resp_ready !== 1'b1) begin n_fail++; $display("FAIL midflight_fifo_cleared: ready=%b want 1", out_resp_ready); end
    n_checks++; if (in0_req_ready !== 1'b1 || in1_req_ready !== 1'b0 || out_req_valid !== 1'b1) begin n_fail++; $display("FAIL midflight_grant_reset: rdy0=%b rdy1=%b valid=%b want 1/0/1", in0_req_ready, in1_req_ready, out_req_valid); end
    step();
    reset_n = 1'b1;
    settle();
    n_checks++; if (in0_req_ready !== 1'b1 || out_req_bits_addr !== 32'h00A0) begin n_fail++; $display("FAIL midflight_after_release: rdy0=%b addr=%h want 1/a0", in0_req_ready, out_req_bits_addr); end
    step();
  endtask

  // Model: a list of owners awaiting responses, the previous winner, and the
  // master whose offered request the device has not yet taken.
  task automatic test_random();
    int owners [$];
    int prev_winner = 1;
    int waiting = -1;
    int w;
    logic full, exp_valid, exp_rdy0, exp_rdy1;
    apply_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req_v[m]) begin
          req_v[m] = 1'($urandom_range(0, 1));
          req_addr[m] = $urandom; req_data[m] = $urandom;
          req_strb[m] = 4'($urandom_range(0, 15)); req_func[m] = 1'($urandom_range(0, 1));
        end
        resp_rdy[m] = ($urandom_range(0, 3) != 0);
      end
      out_req_ready = ($urandom_range(0, 2) != 0);
      out_resp_valid = (owners.size() > 0) && ($urandom_range(0, 1) == 1);
      out_resp_bits_data = $urandom;
      settle();
      full = (owners.size() == DEPTH);
      if (waiting >= 0) w = waiting;
      else if (req_v[0] && req_v[1]) w = 1 - prev_winner;
      else if (req_v[1]) w = 1;
      else w = 0;
      exp_valid = req_v[w] && !full;
      exp_rdy0 = (w == 0) && out_req_ready && !full;
      exp_rdy1 = (w == 1) && out_req_ready && !full;
      n_checks++; if (out_req_valid !== exp_valid || in0_req_ready !== exp_rdy0 || in1_req_ready !== exp_rdy1) begin n_fail++; $display("FAIL random_req cyc%0d: valid=%b rdy0=%b rdy1=%b want %b/%b/%b", cyc, out_req_valid, in0_req_ready, in1_req_ready, exp_valid, exp_rdy0, exp_rdy1); end
      if (exp_valid) begin
        n_checks++; if (out_req_bits_addr !== req_addr[w] || out_req_bits_data !== req_data[w] || out_req_bits_strb !== req_strb[w]) begin n_fail++; $display("FAIL random_bits cyc%0d: addr=%h want %h", cyc, out_req_bits_addr, req_addr[w]); end
      end
      if (owners.size() > 0) begin
        n_checks++; if (in0_resp_valid !== (out_resp_valid && owners[0] == 0) || in1_resp_valid !== (out_resp_valid && owners[0] == 1) || out_resp_ready !== resp_rdy[owners[0]] || in1_resp_bits_data !== out_resp_bits_data) begin n_fail++; $display("FAIL random_resp cyc%0d: v0=%b v1=%b ready=%b head=%0d", cyc, in0_resp_valid, in1_resp_valid, out_resp_ready, owners[0]); end
      end else begin
        n_checks++; if (in0_resp_valid !== 1'b0 || in1_resp_valid !== 1'b0 || out_resp_ready !== 1'b1) begin n_fail++; $display("FAIL random_idle_resp cyc%0d: v0=%b v1=%b ready=%b", cyc, in0_resp_valid, in1_resp_valid, out_resp_ready); end
      end
      step();
      if (owners.size() > 0 && out_resp_valid && resp_rdy[owners[0]]) void'(owners.pop_front());
      if (exp_valid && out_req_ready) begin
        owners.push_back(w);
        prev_winner = w;
        waiting = -1;
        req_v[w] = 1'b0;
      end else if (exp_valid) begin
        waiting = w;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_stall_lock();
    test_full();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
